// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and helpers for the clock divider bank
//
// Purpose : constants shared by clk_div_bank and clk_div_chan.
// Contents: DIV_MIN      smallest divisor the bank accepts
//           CNT_W_DEF    default counter/divisor width
//           ch_idx_w()   width of a channel index for a given channel count
package clk_div_pkg;

  localparam int DIV_MIN   = 2;
  localparam int CNT_W_DEF = 24;

  // A single-channel bank still needs a 1-bit index port.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one programmable divider channel
//
// Purpose : period counter, divisor shadow/pending pair and registered
//           tick / square-wave outputs for a single channel.
// Ports   : clk_i      system clock
//           rst_ni     asynchronous active-low reset
//           en_i       run enable (level)
//           sync_i     restart at phase 0 (pulse)
//           wr_i       accepted, already-validated divisor write
//           wr_div_i   divisor carried by that write
//           pending_o  a written divisor is waiting for a period boundary
//           tick_o     one-cycle pulse at the start of each period
//           sq_o       square wave, high for the first floor(D/2) cycles
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 1_000_000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic             pending_o,
  output logic             tick_o,
  output logic             sq_o
);

  localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             run_q;
  logic             tick_q;
  logic             sq_q, sq_d;
  logic             wrap;
  logic             apply;
  logic [CNT_W-1:0] div_use;

  always_comb begin
    cnt_d     = '0;
    wrap      = 1'b0;
    apply     = 1'b0;
    div_use   = div_act_q;
    sq_d      = 1'b0;
    div_act_d = div_act_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;

    if (!en_i) begin
      cnt_d = '0;
      wrap  = 1'b0;
    end else if (sync_i || !run_q) begin
      // First enabled cycle and sync both restart the period at phase 0.
      cnt_d = '0;
      wrap  = 1'b1;
    end else if (cnt_q == div_act_q - ONE_C) begin
      cnt_d = '0;
      wrap  = 1'b1;
    end else begin
      cnt_d = cnt_q + ONE_C;
    end

    // Swap divisors only at a period boundary (or while idle) so a running
    // period is never built from two different divisors.
    apply   = pending_q & (wrap | ~en_i);
    div_use = apply ? shadow_q : div_act_q;
    sq_d    = en_i & (cnt_d < (div_use >> 1));

    div_act_d = div_use;
    if (apply) begin
      pending_d = 1'b0;
    end
    // The top only forwards a write while pending is clear, so a write can
    // never coincide with an apply on the same channel.
    if (wr_i) begin
      shadow_d  = wr_div_i;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      div_act_q <= DEF_DIV_C;
      shadow_q  <= DEF_DIV_C;
      pending_q <= 1'b0;
      run_q     <= 1'b0;
      tick_q    <= 1'b0;
      sq_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      run_q     <= en_i;
      tick_q    <= wrap;
      sq_q      <= sq_d;
    end
  end

  assign pending_o = pending_q;
  assign tick_o    = tick_q;
  assign sq_o      = sq_q;

endmodule

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - bank of independent programmable clock dividers
//
// Purpose : NUM_CH divider channels sharing one config port and one sync.
// Ports   : clk_in     system clock
//           rst_n      asynchronous active-low reset
//           en_i       per-channel run enable
//           sync_i     restart every enabled channel at phase 0
//           cfg_valid  config request
//           cfg_ready  config accept (low while target channel has a pending divisor)
//           cfg_ch     target channel
//           cfg_div    new divisor (period in clk_in cycles)
//           cfg_err    one-cycle pulse after an accepted but invalid request
//           tick_o     per-channel period tick
//           sq_o       per-channel square wave
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int  NUM_CH      = 2,
  parameter int  CNT_W       = CNT_W_DEF,
  parameter int  DEFAULT_DIV = 1_000_000,
  localparam int CH_W        = ch_idx_w(NUM_CH)
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              sync_i,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] sq_o
);

  localparam int               PAD_N     = 1 << CH_W;
  localparam logic [CNT_W-1:0] DIV_MIN_C = CNT_W'(DIV_MIN);

  logic [NUM_CH-1:0] pending;
  logic [PAD_N-1:0]  pending_pad;
  logic [NUM_CH-1:0] wr;
  logic              ch_ok;
  logic              div_ok;
  logic              hs;
  logic              err_d;
  logic              cfg_err_q;

  // Pad the pending vector to the full index range so an out-of-range
  // channel number never selects past the end of a real vector.
  always_comb begin
    pending_pad               = '0;
    pending_pad[NUM_CH-1:0]   = pending;
  end

  assign ch_ok     = (32'(cfg_ch) < NUM_CH);
  assign div_ok    = (cfg_div >= DIV_MIN_C);
  // Bad channel numbers are always accepted so they can be reported.
  assign cfg_ready = ch_ok ? ~pending_pad[cfg_ch] : 1'b1;
  assign hs        = cfg_valid & cfg_ready;
  assign err_d     = hs & ~(ch_ok & div_ok);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= err_d;
    end
  end

  assign cfg_err = cfg_err_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr[c] = hs & ch_ok & div_ok & (cfg_ch == CH_W'(c));

    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_i     (clk_in),
      .rst_ni    (rst_n),
      .en_i      (en_i[c]),
      .sync_i    (sync_i),
      .wr_i      (wr[c]),
      .wr_div_i  (cfg_div),
      .pending_o (pending[c]),
      .tick_o    (tick_o[c]),
      .sq_o      (sq_o[c])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb/tb_clk_div_bank.sv - self-checking bench for clk_div_bank
module tb_clk_div_bank;

  localparam int NCH  = 3;
  localparam int CW   = 24;
  localparam int DDIV = 10;

  logic           clk_in = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] en_i;
  logic           sync_i;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic           cfg_err;
  logic [NCH-1:0] tick_o;
  logic [NCH-1:0] sq_o;

  clk_div_bank #(
    .NUM_CH      (NCH),
    .CNT_W       (CW),
    .DEFAULT_DIV (DDIV)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .en_i      (en_i),
    .sync_i    (sync_i),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .tick_o    (tick_o),
    .sq_o      (sq_o)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Reference model: time-based view of each channel's period.
  int       m_t;
  int       m_start  [NCH];
  int       m_period [NCH];
  int       m_shadow [NCH];
  bit       m_pend   [NCH];
  bit       m_run    [NCH];
  bit [NCH-1:0] m_tick, m_sq;
  bit       m_err;

  logic rdy_seen;
  logic last_hs;

  typedef struct {
    logic [2:0]  en;
    logic        valid;
    logic [1:0]  ch;
    logic [23:0] dv;
    logic [2:0]  tick;
    logic [2:0]  sq;
    logic        rdy;
    logic        err;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0;
    for (int c = 0; c < NCH; c++) begin
      m_start[c]  = 0;
      m_period[c] = DDIV;
      m_shadow[c] = DDIV;
      m_pend[c]   = 0;
      m_run[c]    = 0;
    end
    m_tick = '0;
    m_sq   = '0;
    m_err  = 0;
  endtask

  task automatic model_step(input logic [NCH-1:0] en, input logic sy, input logic hs,
                            input logic [1:0] ch, input logic [CW-1:0] dv);
    for (int c = 0; c < NCH; c++) begin
      if (!en[c]) begin
        m_tick[c] = 0;
        m_sq[c]   = 0;
        m_run[c]  = 0;
        if (m_pend[c]) begin
          m_period[c] = m_shadow[c];
          m_pend[c]   = 0;
        end
      end else begin
        if (sy || !m_run[c] || (m_t - m_start[c] == m_period[c])) begin
          m_start[c] = m_t;
          m_tick[c]  = 1;
          if (m_pend[c]) begin
            m_period[c] = m_shadow[c];
            m_pend[c]   = 0;
          end
        end else begin
          m_tick[c] = 0;
        end
        m_sq[c]  = ((m_t - m_start[c]) < (m_period[c] / 2));
        m_run[c] = 1;
      end
    end
    m_err = 0;
    if (hs) begin
      if (int'(ch) < NCH && int'(dv) >= 2) begin
        m_shadow[ch] = int'(dv);
        m_pend[ch]   = 1;
      end else begin
        m_err = 1;
      end
    end
    m_t++;
  endtask

  // One clock: check cfg_ready mid-cycle, clock, check registered outputs.
  task automatic cycle();
    logic           exp_rdy, hs;
    logic [NCH-1:0] en_s;
    logic           sy_s;
    logic [1:0]     ch_s;
    logic [CW-1:0]  dv_s;
    #2;
    exp_rdy = (int'(cfg_ch) >= NCH) ? 1'b1 : !m_pend[cfg_ch];
    rdy_seen = cfg_ready;
    chk("cfg_ready", cfg_ready, exp_rdy);
    hs   = cfg_valid && exp_rdy;
    en_s = en_i; sy_s = sync_i; ch_s = cfg_ch; dv_s = cfg_div;
    @(posedge clk_in);
    #1;
    model_step(en_s, sy_s, hs, ch_s, dv_s);
    chk("tick_o", tick_o, m_tick);
    chk("sq_o", sq_o, m_sq);
    chk("cfg_err", cfg_err, m_err);
    last_hs = hs;
    if (hs) cfg_valid = 1'b0;
  endtask

  task automatic run_until_tick(input int c, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!tick_o[c] && n < 64);
  endtask

  initial begin
    int n;
    logic [2:0] seen;

    //         en     v  ch  dv   tick    sq      rdy err
    tbl[0]  = '{3'b000, 1, 0, 4,  3'b000, 3'b000, 1, 0};
    tbl[1]  = '{3'b000, 0, 0, 0,  3'b000, 3'b000, 0, 0};
    tbl[2]  = '{3'b001, 0, 0, 0,  3'b001, 3'b001, 1, 0};
    tbl[3]  = '{3'b001, 0, 0, 0,  3'b000, 3'b001, 1, 0};
    tbl[4]  = '{3'b001, 0, 0, 0,  3'b000, 3'b000, 1, 0};
    tbl[5]  = '{3'b001, 0, 0, 0,  3'b000, 3'b000, 1, 0};
    tbl[6]  = '{3'b001, 0, 0, 0,  3'b001, 3'b001, 1, 0};
    tbl[7]  = '{3'b001, 1, 0, 1,  3'b000, 3'b001, 1, 1};
    tbl[8]  = '{3'b001, 1, 3, 5,  3'b000, 3'b000, 1, 1};
    tbl[9]  = '{3'b001, 0, 0, 0,  3'b000, 3'b000, 1, 0};
    tbl[10] = '{3'b001, 0, 0, 0,  3'b001, 3'b001, 1, 0};

    rst_n = 1'b0; en_i = '0; sync_i = 0; cfg_valid = 0; cfg_ch = 0; cfg_div = 0;
    last_hs = 0; rdy_seen = 0;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1 rst_n = 1'b1;
    #1;
    chk("reset_tick", tick_o, 0);
    chk("reset_sq", sq_o, 0);
    chk("reset_err", cfg_err, 0);
    chk("reset_ready", cfg_ready, 1);

    // Idle: no ticks while disabled.
    for (int i = 0; i < 100; i++) cycle();

    // Directed table: D=4 start, invalid writes.
    for (int i = 0; i < 11; i++) begin
      en_i = tbl[i].en; cfg_valid = tbl[i].valid; cfg_ch = tbl[i].ch; cfg_div = tbl[i].dv;
      cycle();
      chk("tbl_ready", rdy_seen, tbl[i].rdy);
      chk("tbl_tick", tick_o, tbl[i].tick);
      chk("tbl_sq", sq_o, tbl[i].sq);
      chk("tbl_err", cfg_err, tbl[i].err);
    end
    cfg_valid = 0; cfg_ch = 0;

    // Mid-period divisor change with a stalled second write.
    cfg_valid = 1; cfg_ch = 0; cfg_div = 6;
    cycle();
    cfg_valid = 1; cfg_div = 8;
    cycle();
    chk("stall_ready", rdy_seen, 0);
    run_until_tick(0, n);
    chk("gap_old_div", n, 2);
    run_until_tick(0, n);
    chk("gap_new_div", n, 6);
    run_until_tick(0, n);
    chk("gap_second_write", n, 8);

    // Sync alignment of two channels.
    cfg_valid = 1; cfg_ch = 0; cfg_div = 4;
    cycle();
    cfg_valid = 1; cfg_ch = 1; cfg_div = 6;
    cycle();
    cfg_ch = 0;
    en_i = 3'b011;
    for (int i = 0; i < 20; i++) cycle();
    sync_i = 1;
    cycle();
    sync_i = 0;
    chk("sync_tick", tick_o, 3'b011);
    for (int i = 1; i <= 6; i++) begin
      cycle();
      seen = {1'b0, (i == 6), (i == 4)};
      chk("post_sync_tick", {1'b0, tick_o[1:0]}, seen);
    end

    // Async reset with a pending write.
    en_i = 3'b001;
    cfg_valid = 1; cfg_ch = 0; cfg_div = 6;
    cycle();
    run_until_tick(0, n);
    run_until_tick(0, n);
    chk("gap_d6", n, 6);
    cfg_valid = 1; cfg_ch = 0; cfg_div = 9;
    cycle();
    chk("pre_reset_sq", sq_o[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_tick", tick_o, 0);
    chk("async_sq", sq_o, 0);
    chk("async_err", cfg_err, 0);
    chk("async_ready", cfg_ready, 1);
    cfg_valid = 0; en_i = '0;
    repeat (2) @(posedge clk_in);
    #1 rst_n = 1'b1;
    model_reset();
    en_i = 3'b001;
    run_until_tick(0, n);
    chk("reenable_latency", n, 1);
    run_until_tick(0, n);
    chk("gap_default", n, DDIV);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) en_i = 3'($urandom_range(0, 7));
      sync_i = ($urandom_range(0, 39) == 0);
      if (!cfg_valid && $urandom_range(0, 7) == 0) begin
        cfg_valid = 1;
        cfg_ch    = 2'($urandom_range(0, 3));
        cfg_div   = CW'($urandom_range(0, 14));
      end
      cycle();
    end
    sync_i = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Bank of NUM_CH independent programmable clock dividers driven from the 100 MHz board clock. Each channel emits a one-cycle clock-enable tick and a registered square wave whose period is set at runtime through a valid/ready config port. New divisors take effect glitch-free at the next period boundary. A common sync pulse phase-aligns all running channels. The bank replaces single fixed-rate slow-clock generators as the timebase source for LFSR stepping, display refresh and debounce.

## Interface
- NUM_CH, 2: number of divider channels (1..16)
- CNT_W, 24: counter/divisor width
- DEFAULT_DIV, 1_000_000: divisor loaded at reset (100 Hz at 100 MHz); must satisfy 2 ≤ DEFAULT_DIV < 2^CNT_W
- clk_in  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- en_i  in  NUM_CH  per-channel run enable (level)
- sync_i  in  1  restart all enabled channels at phase 0 (pulse)
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accept = !pending[cfg_ch]; evaluated only when cfg_ch < NUM_CH, and is 1 when cfg_ch ≥ NUM_CH
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel
- cfg_div  in  CNT_W  new divisor D = output period in clk_in cycles
- cfg_err  out  1  one-cycle pulse: accepted request rejected (D < 2 or cfg_ch ≥ NUM_CH)
- tick_o  out  NUM_CH  one-cycle pulse per period
- sq_o  out  NUM_CH  square wave, ~50 % duty

## Operation
- Per-channel state: cnt (CNT_W), div_act, shadow, pending, run_q.
- The divisor used for the current cycle (div_use) is the new divisor when an apply occurs this cycle (see below), else div_act.
- Next-state rules, in priority order:
  - !en_i[c]: cnt_nxt = 0, wrap = 0.
  - sync_i or !run_q: cnt_nxt = 0, wrap = 1.
  - cnt == div_act−1: cnt_nxt = 0, wrap = 1.
  - Otherwise: cnt_nxt = cnt + 1, wrap = 0.
- Registered outputs:
  - tick_o[c] <= wrap.
  - sq_o[c] <= en_i[c] & (cnt_nxt < (div_use >> 1)).
  - run_q <= en_i[c].
- Odd D: high for floor(D/2) cycles, low for ceil(D/2) cycles.
- Config handshake completes on cfg_valid & cfg_ready.
  - Valid request: shadow <= cfg_div, pending <= 1.
  - Invalid request: nothing stored; cfg_err pulses the following cycle.
- Apply: when pending and (wrap or !en_i[c]), div_act <= shadow and pending <= 0. div_use equals shadow that cycle.
- An active channel's period never mixes old and new divisors.
- A second write to the same channel stalls (cfg_ready = 0) until the first is applied. Writes to other channels are unaffected.
- Disabling a channel mid-period: outputs go to 0 on the next edge and cnt is cleared. div_act and any pending shadow are kept; pending applies next cycle.

## Timing
- Reset values:
  - tick_o = 0, sq_o = 0, cfg_err = 0.
  - cnt = 0, run_q = 0, pending = 0, div_act = DEFAULT_DIV.
  - cfg_ready = 1.
- Enable latency: en_i sampled high at edge k gives tick_o = 1 and sq_o = 1 from edge k. Subsequent ticks follow at edges k + n·D.
- sync_i sampled at edge k: every enabled channel ticks at edge k, then at k + n·D. A sync on the channel's first enabled cycle behaves identically to a plain start.
- Config write accepted at edge k on an idle (disabled) channel: div_act is updated at edge k+1.
- cnt never exceeds div_act−1; no wrap-around beyond 2^CNT_W is possible.

## Structure
- Package clk_div_pkg: DIV_MIN = 2, default CNT_W, channel-index width function.
- Sub-module clk_div_chan contains one channel's counter, shadow/pending and output flops. It is instantiated NUM_CH times by generate.
- The top level holds config decode, cfg_ready mux and cfg_err flop.

## Test plan
- Reset, then hold en_i = 0: all outputs 0, cfg_ready = 1, no ticks for 100 cycles.
- D = 4 on ch0, en_i[0] rises at edge 0: ticks at edges 0, 4, 8. sq_o high after edges 0–1, low after edges 2–3.
- ch0 running D = 4, write D = 6 mid-period: one more 4-cycle period, then 6-cycle periods. cfg_ready low until the apply. A second write during the stall is held off.
- ch0 D = 4, ch1 D = 6, sync_i at edge 10: both tick at 10. ch0 ticks at 14, ch1 at 16.
- Write D = 1 and write cfg_ch = NUM_CH: handshake completes, cfg_err pulses once each time, divisors unchanged.
- Assert rst_n low mid-period with a pending write: outputs 0 immediately (async), pending cleared, DEFAULT_DIV period after release and re-enable.
